hist_readout: RTL

Readout engine for the photon-hit histograms kept by the coincidence/veto logic: on a start request it snapshots the 8 per-channel hit counts and the 64 inter-photon-interval bins, then streams them as a framed byte sequence over a valid/ready byte interface to the host link (USB/UART bridge). It can optionally pulse the histogram-clear line once the frame has gone out, closing the write/read loop on the histograms.

---
 rtl/hist_readout.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/hist_readout.sv
// hist_readout: snapshots the hit-count and inter-photon-interval histograms on a start request.
// It then streams them as a framed byte sequence over a valid/ready byte interface:
//   0xA5, word count, histo[0..NBINS-1], ipihist[0..NIPI-1] (each word 4 bytes, little-endian)
// Optional build macro HIST_READOUT_CHECKSUM_EN appends one XOR byte covering the data bytes.
// When clear_after was set with start, resethist is pulsed for 2 cycles after the frame.
module hist_readout #(
  parameter int unsigned NBINS = 8,
  parameter int unsigned NIPI  = 64
) (
  input  logic                clkin,
  input  logic                nrst,
  input  logic                start,
  input  logic                clear_after,
  input  logic [NBINS*32-1:0] histo_flat,
  input  logic [NIPI*32-1:0]  ipihist_flat,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done,
  output logic                resethist,
  output logic [7:0]          dropped_starts
);

  localparam int unsigned NWORDS = NBINS + NIPI;
  localparam int unsigned NBYTES = 4 * NWORDS;
  localparam int unsigned SW     = 32 * NWORDS;
  localparam int unsigned CW     = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

`ifdef HIST_READOUT_CHECKSUM_EN
  typedef enum logic [2:0] {Idle, Hdr, Cnt, Data, Csum, Clr} state_t;
`else
  typedef enum logic [2:0] {Idle, Hdr, Cnt, Data, Clr} state_t;
`endif

  state_t          state;
  // Snapshot doubles as a shift register: the byte on deck always sits in snap[7:0].
  logic [SW-1:0]   snap;
  logic [CW-1:0]   byte_cnt;
  logic            clear_lat;
  logic            clr_cnt;
  logic            accept;
`ifdef HIST_READOUT_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign accept = tx_valid & tx_ready;

  // Frame sequencer with registered outputs; dropped-start counter rides along.
  always_ff @(posedge clkin or negedge nrst) begin
    if (!nrst) begin
      state          <= Idle;
      snap           <= '0;
      byte_cnt       <= '0;
      clear_lat      <= 1'b0;
      clr_cnt        <= 1'b0;
      tx_data        <= 8'h00;
      tx_valid       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      resethist      <= 1'b0;
      dropped_starts <= 8'h00;
`ifdef HIST_READOUT_CHECKSUM_EN
      csum           <= 8'h00;
`endif
    end else begin
      done <= 1'b0;

      if (start && (state != Idle) && (dropped_starts != 8'hFF)) begin
        dropped_starts <= dropped_starts + 8'd1;
      end

      unique case (state)
        Idle: begin
          if (start) begin
            state     <= Hdr;
            snap      <= {ipihist_flat, histo_flat};
            clear_lat <= clear_after;
            byte_cnt  <= '0;
            tx_data   <= 8'hA5;
            tx_valid  <= 1'b1;
            busy      <= 1'b1;
`ifdef HIST_READOUT_CHECKSUM_EN
            csum      <= 8'h00;
`endif
          end
        end

        Hdr: begin
          if (accept) begin
            state   <= Cnt;
            tx_data <= 8'(NWORDS);
          end
        end

        Cnt: begin
          if (accept) begin
            state    <= Data;
            byte_cnt <= '0;
            tx_data  <= snap[7:0];
            snap     <= snap >> 8;
          end
        end

        Data: begin
          if (accept) begin
`ifdef HIST_READOUT_CHECKSUM_EN
            csum <= csum ^ tx_data;
`endif
            if (byte_cnt == LAST_BYTE) begin
`ifdef HIST_READOUT_CHECKSUM_EN
              state   <= Csum;
              tx_data <= csum ^ tx_data;
`else
              tx_valid <= 1'b0;
              if (clear_lat) begin
                state     <= Clr;
                resethist <= 1'b1;
                clr_cnt   <= 1'b0;
              end else begin
                state <= Idle;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
`endif
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
              tx_data  <= snap[7:0];
              snap     <= snap >> 8;
            end
          end
        end

`ifdef HIST_READOUT_CHECKSUM_EN
        Csum: begin
          if (accept) begin
            tx_valid <= 1'b0;
            if (clear_lat) begin
              state     <= Clr;
              resethist <= 1'b1;
              clr_cnt   <= 1'b0;
            end else begin
              state <= Idle;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
`endif

        Clr: begin
          // Second cycle of the clear pulse ends the frame.
          if (clr_cnt) begin
            state     <= Idle;
            resethist <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            clr_cnt <= 1'b1;
          end
        end

        default: begin
          state     <= Idle;
          tx_valid  <= 1'b0;
          busy      <= 1'b0;
          resethist <= 1'b0;
        end
      endcase
    end
  end

endmodule
